// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALU control at capture and holds it in a 2-entry skid buffer.
// Optional operand forwarding at capture is enabled by defining ALU_FWD_EN.
module alu_issue_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_aluop,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic [31:0] in_imm,
    input  logic        in_alusrc,
    input  logic [4:0]  in_rs_addr,
    input  logic [4:0]  in_rt_addr,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] read1,
    output logic [31:0] read2,
    output logic [3:0]  operation,
    output logic [4:0]  out_rd,
    output logic        illegal
`ifdef ALU_FWD_EN
    ,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] read1;
        logic [31:0] read2;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_in_ready;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    entry_t      r_mem [DEPTH];

    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_op;
    logic        w_illegal;
    logic [31:0] w_rs;
    logic [31:0] w_rt;
    entry_t      w_entry;

    // Forwarding never applies to register 0, which always reads as zero.
`ifdef ALU_FWD_EN
    assign w_rs = (fwd_valid && (fwd_rd == in_rs_addr) && (fwd_rd != 5'd0)) ? fwd_data : in_rs_data;
    assign w_rt = (fwd_valid && (fwd_rd == in_rt_addr) && (fwd_rd != 5'd0)) ? fwd_data : in_rt_data;
`else
    logic w_unused;
    assign w_unused = ^{in_rs_addr, in_rt_addr};
    assign w_rs     = in_rs_data;
    assign w_rt     = in_rt_data;
`endif

    always_comb begin
        w_op      = 4'b1111;
        w_illegal = 1'b0;
        unique case (in_aluop)
            2'b00: w_op = 4'b0010;
            2'b01: w_op = 4'b0110;
            2'b11: w_op = 4'b0111;
            2'b10: begin
                case (in_funct)
                    6'b100000: w_op = 4'b0010;
                    6'b100010: w_op = 4'b0110;
                    6'b100100: w_op = 4'b0000;
                    6'b100101: w_op = 4'b0001;
                    6'b101010: w_op = 4'b0111;
                    6'b100111: w_op = 4'b1100;
                    default: begin
                        w_op      = 4'b1111;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            default: w_op = 4'b1111;
        endcase
    end

    assign w_entry.read1   = w_rs;
    assign w_entry.read2   = in_alusrc ? in_imm : w_rt;
    assign w_entry.op      = w_op;
    assign w_entry.rd      = in_rd;
    assign w_entry.illegal = w_illegal;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = out_ready && (r_state != EMPTY);

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: if (w_push) w_state_nxt = ONE;
                ONE: begin
                    if (w_push && !w_pop) w_state_nxt = FULL;
                    else if (w_pop && !w_push) w_state_nxt = EMPTY;
                end
                FULL:    if (w_pop) w_state_nxt = ONE;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
            if (flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= ~r_wr_ptr;
                if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign read1     = r_mem[r_rd_ptr].read1;
    assign read2     = r_mem[r_rd_ptr].read2;
    assign operation = r_mem[r_rd_ptr].op;
    assign out_rd    = r_mem[r_rd_ptr].rd;
    assign illegal   = r_mem[r_rd_ptr].illegal;

endmodule
